// File: rtl/ras_stack_if.sv
// ============================================================================
//  Module      : ras_stack_if
//  Description : Predictor <-> return-address-stack signal bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ras_stack_if #(
  parameter int RAS_ENTRIES      = 8,
  parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
  parameter int RAS_TARGET_WIDTH = 31
);
  logic                        link_valid;
  logic [RAS_TARGET_WIDTH-1:0] link_pc;
  logic                        ret_valid;
  logic [RAS_TARGET_WIDTH-1:0] ret_target;
  logic                        ret_hit;
  logic [RAS_INDEX_WIDTH-1:0]  ras_index;
  logic [RAS_INDEX_WIDTH:0]    ras_count;
  logic                        restore_valid;
  logic [RAS_INDEX_WIDTH-1:0]  restore_index;
  logic [RAS_INDEX_WIDTH:0]    restore_count;

  modport master (
    output link_valid, link_pc, ret_valid,
    output restore_valid, restore_index, restore_count,
    input  ret_target, ret_hit, ras_index, ras_count
  );

  modport slave (
    input  link_valid, link_pc, ret_valid,
    input  restore_valid, restore_index, restore_count,
    output ret_target, ret_hit, ras_index, ras_count
  );
endinterface

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack with checkpoint restore.
//                Optional macro RAS_PERF_CNT_EN adds saturating
//                overflow_cnt / underflow_cnt outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack #(
  parameter int RAS_ENTRIES      = 8,
  parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
  parameter int RAS_TARGET_WIDTH = 31
) (
  input  wire logic   CLK,
  input  wire logic   RST,
  ras_stack_if.slave  ras
`ifdef RAS_PERF_CNT_EN
  ,
  output logic [15:0] overflow_cnt,
  output logic [15:0] underflow_cnt
`endif
);

  localparam logic [RAS_INDEX_WIDTH:0]   c_full_count = RAS_ENTRIES[RAS_INDEX_WIDTH:0];
  localparam logic [RAS_INDEX_WIDTH:0]   c_one_count  = 1;
  localparam logic [RAS_INDEX_WIDTH-1:0] c_one_index  = 1;

  logic [RAS_TARGET_WIDTH-1:0] r_mem [RAS_ENTRIES];
  logic [RAS_INDEX_WIDTH-1:0]  r_head;
  logic [RAS_INDEX_WIDTH:0]    r_count;

  logic                        w_push;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_empty;
  logic [RAS_INDEX_WIDTH-1:0]  w_head_inc;
  logic [RAS_INDEX_WIDTH-1:0]  w_head_dec;
  logic [RAS_INDEX_WIDTH-1:0]  w_head_nxt;
  logic [RAS_INDEX_WIDTH:0]    w_count_nxt;
  logic [RAS_INDEX_WIDTH:0]    w_restore_count;
  logic                        w_wr_en;
  logic [RAS_INDEX_WIDTH-1:0]  w_wr_addr;

  // A restore cancels any push or pop presented in the same cycle.
  assign w_push     = ras.link_valid & ~ras.restore_valid;
  assign w_pop      = ras.ret_valid  & ~ras.restore_valid;
  assign w_full     = (r_count == c_full_count);
  assign w_empty    = (r_count == '0);
  assign w_head_inc = r_head + c_one_index;
  assign w_head_dec = r_head - c_one_index;

  assign w_restore_count = (ras.restore_count > c_full_count) ? c_full_count
                                                              : ras.restore_count;

  always_comb begin
    w_head_nxt  = r_head;
    w_count_nxt = r_count;
    w_wr_en     = 1'b0;
    w_wr_addr   = w_head_inc;
    if (ras.restore_valid) begin
      w_head_nxt  = ras.restore_index;
      w_count_nxt = w_restore_count;
    end else if (w_push && w_pop) begin
      // Call and return together replace the top in place.
      w_wr_en   = 1'b1;
      w_wr_addr = r_head;
    end else if (w_push) begin
      w_head_nxt = w_head_inc;
      w_wr_en    = 1'b1;
      w_wr_addr  = w_head_inc;
      if (!w_full) begin
        w_count_nxt = r_count + c_one_count;
      end
    end else if (w_pop) begin
      w_head_nxt = w_head_dec;
      if (!w_empty) begin
        w_count_nxt = r_count - c_one_count;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[w_wr_addr] <= ras.link_pc;
    end
  end

  assign ras.ret_target = r_mem[r_head];
  assign ras.ret_hit    = ~w_empty;
  assign ras.ras_index  = r_head;
  assign ras.ras_count  = r_count;

`ifdef RAS_PERF_CNT_EN
  logic w_overflow;
  logic w_underflow;

  assign w_overflow  = w_push & ~w_pop & w_full;
  assign w_underflow = w_pop & ~w_push & w_empty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overflow_cnt  <= '0;
      underflow_cnt <= '0;
    end else begin
      if (w_overflow && (overflow_cnt != 16'hFFFF)) begin
        overflow_cnt <= overflow_cnt + 16'd1;
      end
      if (w_underflow && (underflow_cnt != 16'hFFFF)) begin
        underflow_cnt <= underflow_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ras_stack.sv
// ============================================================================
//  Module      : tb_ras_stack
//  Description : Directed self-checking bench for ras_stack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ras_stack;

  localparam int c_entries = 8;
  localparam int c_iw      = 3;
  localparam int c_tw      = 31;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference stack: expected pop results, newest at the back.
  logic [c_tw-1:0] sb_q [$];

`ifdef RAS_PERF_CNT_EN
  logic [15:0] overflow_cnt;
  logic [15:0] underflow_cnt;
`endif

  ras_stack_if #(
    .RAS_ENTRIES     (c_entries),
    .RAS_INDEX_WIDTH (c_iw),
    .RAS_TARGET_WIDTH(c_tw)
  ) ras_bus ();

  ras_stack #(
    .RAS_ENTRIES     (c_entries),
    .RAS_INDEX_WIDTH (c_iw),
    .RAS_TARGET_WIDTH(c_tw)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ras          (ras_bus)
`ifdef RAS_PERF_CNT_EN
    ,
    .overflow_cnt (overflow_cnt),
    .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [c_tw-1:0] pc, input logic rv,
                       input logic rsv, input logic [c_iw-1:0] ri, input logic [c_iw:0] rc);
    ras_bus.link_valid    = lv;
    ras_bus.link_pc       = pc;
    ras_bus.ret_valid     = rv;
    ras_bus.restore_valid = rsv;
    ras_bus.restore_index = ri;
    ras_bus.restore_count = rc;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic push(input logic [c_tw-1:0] pc);
    drive(1'b1, pc, 1'b0, 1'b0, '0, '0);
    sb_q.push_back(pc);
    if (sb_q.size() > c_entries) void'(sb_q.pop_front());
    tick();
  endtask

  task automatic pop_check(input string tag);
    logic [c_tw-1:0] exp;
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    exp = sb_q.pop_back();
    check({tag, "_hit"}, 32'(ras_bus.ret_hit), 32'd1);
    check(tag, 32'(ras_bus.ret_target), 32'(exp));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_hit",    32'(ras_bus.ret_hit),    32'd0);
    check("rst_index",  32'(ras_bus.ras_index),  32'd0);
    check("rst_count",  32'(ras_bus.ras_count),  32'd0);
    check("rst_target", 32'(ras_bus.ret_target), 32'd0);
    RST = 1'b0;

    // Basic LIFO ordering.
    push(31'h100);
    push(31'h200);
    push(31'h300);
    idle();
    check("lifo_count", 32'(ras_bus.ras_count), 32'd3);
    check("lifo_index", 32'(ras_bus.ras_index), 32'd3);
    pop_check("lifo_pop0");
    pop_check("lifo_pop1");
    pop_check("lifo_pop2");
    idle();
    check("lifo_empty_hit", 32'(ras_bus.ret_hit), 32'd0);
    check("lifo_empty_idx", 32'(ras_bus.ras_index), 32'd0);

    // Pop while empty: head wraps, count holds at zero.
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    check("uf_hit", 32'(ras_bus.ret_hit), 32'd0);
    tick();
    idle();
    check("uf_count", 32'(ras_bus.ras_count), 32'd0);
    check("uf_index", 32'(ras_bus.ras_index), 32'd7);
`ifdef RAS_PERF_CNT_EN
    check("uf_cnt", 32'(underflow_cnt), 32'd1);
`endif

    // Nine pushes overwrite the oldest entry.
    for (int i = 1; i <= 9; i++) push(31'(i));
    idle();
    check("of_count", 32'(ras_bus.ras_count), 32'd8);
`ifdef RAS_PERF_CNT_EN
    check("of_cnt", 32'(overflow_cnt), 32'd1);
`endif
    for (int i = 0; i < 8; i++) pop_check($sformatf("of_pop%0d", i));
    idle();
    check("of_empty_hit", 32'(ras_bus.ret_hit), 32'd0);

    // Simultaneous push and pop replaces the top.
    push(31'hA);
    push(31'hB);
    drive(1'b1, 31'hC, 1'b1, 1'b0, '0, '0);
    check("pp_target", 32'(ras_bus.ret_target), 32'hB);
    void'(sb_q.pop_back());
    sb_q.push_back(31'hC);
    tick();
    idle();
    check("pp_top",   32'(ras_bus.ret_target), 32'hC);
    check("pp_count", 32'(ras_bus.ras_count),  32'd2);
    check("cp_index", 32'(ras_bus.ras_index),  32'd2);

    // Checkpoint restore beats a concurrent push.
    push(31'hD);
    push(31'hE);
    pop_check("cp_pop");
    drive(1'b1, 31'hF, 1'b0, 1'b1, 3'd2, 4'd2);
    tick();
    idle();
    check("rs_index",  32'(ras_bus.ras_index),  32'd2);
    check("rs_count",  32'(ras_bus.ras_count),  32'd2);
    check("rs_top",    32'(ras_bus.ret_target), 32'hC);
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    tick();
    idle();
    check("rs_next", 32'(ras_bus.ret_target), 32'hA);

    // Oversized restore count is clamped.
    drive(1'b0, '0, 1'b0, 1'b1, 3'd5, 4'd12);
    tick();
    idle();
    check("clamp_count", 32'(ras_bus.ras_count), 32'd8);
    check("clamp_index", 32'(ras_bus.ras_index), 32'd5);

    // Asynchronous reset in the middle of a push.
    drive(1'b1, 31'h55, 1'b0, 1'b0, '0, '0);
    #2;
    RST = 1'b1;
    #1;
    check("arst_count",  32'(ras_bus.ras_count),  32'd0);
    check("arst_index",  32'(ras_bus.ras_index),  32'd0);
    check("arst_hit",    32'(ras_bus.ret_hit),    32'd0);
    check("arst_target", 32'(ras_bus.ret_target), 32'd0);
    tick();
    idle();
    RST = 1'b0;
    check("arst_hold_count", 32'(ras_bus.ras_count), 32'd0);
`ifdef RAS_PERF_CNT_EN
    check("arst_of_cnt", 32'(overflow_cnt),  32'd0);
    check("arst_uf_cnt", 32'(underflow_cnt), 32'd0);
`endif
    drive(1'b1, 31'h77, 1'b0, 1'b0, '0, '0);
    tick();
    idle();
    check("post_count",  32'(ras_bus.ras_count),  32'd1);
    check("post_index",  32'(ras_bus.ras_index),  32'd1);
    check("post_target", 32'(ras_bus.ret_target), 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ras_stack.md
RAS_STACK -- requirements
Module: ras_stack

Interface
REQ-001 SHALL have parameter RAS_ENTRIES, default 8: stack depth; power of 2, at least 2.
REQ-002 SHALL have parameter RAS_INDEX_WIDTH, default $clog2(RAS_ENTRIES): width of the head pointer.
REQ-003 SHALL have parameter RAS_TARGET_WIDTH, default 31: width of the stored return target, which is PC[31:1].
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port link_valid, input, 1 bit: a call was predicted this cycle; push its link address.
REQ-007 SHALL have port link_pc, input, RAS_TARGET_WIDTH bits: the return address to push.
REQ-008 SHALL have port ret_valid, input, 1 bit: a return was predicted this cycle; pop.
REQ-009 SHALL have port ret_target, output, RAS_TARGET_WIDTH bits: the entry at head, combinational.
REQ-010 SHALL have port ret_hit, output, 1 bit: count is non-zero, so ret_target is meaningful.
REQ-011 SHALL have port ras_index, output, RAS_INDEX_WIDTH bits: current head, for branch checkpointing.
REQ-012 SHALL have port ras_count, output, RAS_INDEX_WIDTH+1 bits: current occupancy, for checkpointing.
REQ-013 SHALL have port restore_valid, input, 1 bit: a mispredict recovery is in progress.
REQ-014 SHALL have port restore_index, input, RAS_INDEX_WIDTH bits: checkpointed head to restore.
REQ-015 SHALL have port restore_count, input, RAS_INDEX_WIDTH+1 bits: checkpointed count to restore.

Function
REQ-016 Storage SHALL be a circular array of RAS_ENTRIES entries; head points at the top-of-stack entry; all index arithmetic SHALL be modulo RAS_ENTRIES.
REQ-017 Push only: next cycle head = head+1 (wrapping); entry[head+1] = link_pc; count = min(count+1, RAS_ENTRIES).
REQ-018 Push when full: SHALL overwrite the oldest entry and keep count = RAS_ENTRIES.
REQ-019 Pop only: ret_target = entry[head] in the same cycle; next cycle head = head-1 (wrapping); count = max(count-1, 0).
REQ-020 Pop when count = 0: ret_hit = 0; head SHALL still decrement and count SHALL stay 0.
REQ-021 Push and pop in the same cycle: ret_target = old entry[head]; entry[head] = link_pc; head and count unchanged.
REQ-022 restore_valid SHALL have priority over push and pop: next cycle head = restore_index and count = restore_count; array contents are unchanged and any push or pop that cycle is dropped.
REQ-023 restore_count greater than RAS_ENTRIES SHALL be clamped to RAS_ENTRIES.
REQ-024 ret_target, ret_hit, ras_index and ras_count SHALL reflect registered state only (no input-to-output combinational path).

Reset
REQ-025 While RST is high: head = 0, count = 0, ret_hit = 0, ras_index = 0, ras_count = 0, array entries = 0, and perf counters (if present) = 0.
REQ-026 RST asserted mid-push or mid-restore SHALL discard that operation; the first update happens on the first rising edge after RST deasserts.

Configuration
REQ-027 Macro RAS_PERF_CNT_EN, when defined, SHALL add output overflow_cnt (16 bits), incremented on each push when full (REQ-018), saturating at 0xFFFF.
REQ-028 Macro RAS_PERF_CNT_EN, when defined, SHALL add output underflow_cnt (16 bits), incremented on each pop when empty (REQ-020), saturating at 0xFFFF.
REQ-029 When RAS_PERF_CNT_EN is undefined, those ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Reset, then push 0x100, 0x200, 0x300 -> ras_count = 3, ras_index = 3; three pops return 0x300, 0x200, 0x100, then ret_hit = 0.
REQ-031 Nine pushes of 0x1..0x9 into the 8-entry stack -> count = 8; eight pops return 0x9..0x2; overflow_cnt = 1 if enabled.
REQ-032 Stack holding {0xA, 0xB (top)}, push 0xC and pop in the same cycle -> ret_target = 0xB that cycle; next cycle top = 0xC, count = 2.
REQ-033 Capture index 2 / count 2, push twice, pop once, assert restore_valid with a simultaneous push -> head = 2, count = 2, push dropped, top is the original entry[2].
REQ-034 Pop while empty -> ret_hit = 0, count stays 0, head wraps from 0 to 7; underflow_cnt = 1 if enabled.
REQ-035 Assert RST asynchronously between edges during a push -> outputs are 0 immediately and the push is not applied.
